dec_exe_skid_stage: RTL
=======================

Name: dec_exe_skid_stage

Overview:
- Parametrised decode-to-execute pipeline stage; successor to the plain stall/kill latch between decode and exe.
- Adds a valid/ready handshake on both sides, an optional two-entry skid buffer, and a kill that flushes every held instruction.
- Adds saturating stall and bubble performance counters.
- Sits between the register-read/decode stage and the execute stage; payload is operand A, operand B, destination address, int write enable, instruction and PC.

Parameters:
- DATA_W, 32: operand width.
- ADDR_W, 5: destination register address width.
- INSTR_W, 32: instruction width.
- PC_W, 32: PC width.
- SKID_EN, 1: 1 = two-entry skid buffer with registered upstream ready; 0 = single entry with combinational ready.
- CNT_W, 16: performance counter width.

Ports:
- clk_i  in  1  clock.
- rsn_i  in  1  synchronous active-low reset.
- kill_i  in  1  flush all held entries (branch/exception redirect).
- dec_valid_i  in  1  decode presents an instruction.
- dec_ready_o  out  1  stage can accept this cycle.
- dec_read_data_a_i  in  DATA_W  operand A.
- dec_read_data_b_i  in  DATA_W  operand B.
- dec_write_addr_i  in  ADDR_W  destination register.
- dec_int_write_enable_i  in  1  integer register write.
- dec_instruction_i  in  INSTR_W  instruction.
- dec_pc_i  in  PC_W  PC.
- exe_valid_o  out  1  head entry valid.
- exe_ready_i  in  1  execute accepts head entry.
- exe_read_data_a_o, exe_read_data_b_o, exe_write_addr_o, exe_int_write_enable_o, exe_instruction_o, exe_pc_o  out  matching widths  head entry payload.
- stall_cnt_o  out  CNT_W  cycles with exe_valid_o=1 and exe_ready_i=0.
- bubble_cnt_o  out  CNT_W  cycles with exe_valid_o=0 and exe_ready_i=1.

Behaviour:
- Clocking: one clock. Reset is synchronous, active-low, on rsn_i. All state updates on posedge clk_i.
- Handshakes:
  - in_fire = dec_valid_i & dec_ready_o.
  - out_fire = exe_valid_o & exe_ready_i.
- Reset (rsn_i=0):
  - State goes to EMPTY.
  - All payload registers and both counters go to 0.
  - exe_valid_o=0.
  - dec_ready_o=1 after reset, including the reset cycle itself.
- Kill (kill_i=1, rsn_i=1):
  - State goes to EMPTY and all payload registers are zeroed.
  - Any same-cycle in_fire is dropped.
  - Counters still update from the pre-edge exe_valid_o/exe_ready_i.
  - Kill has priority over every handshake; reset has priority over kill.
- exe_int_write_enable_o = stored enable AND exe_valid_o, so it is never 1 while the stage is empty.
- Latency: 1 cycle from in_fire to exe_valid_o when empty.
- Ordering: strict FIFO; no data is lost or duplicated.
- SKID_EN=1, FSM states EMPTY, ONE, FULL (main entry + skid entry):
  - EMPTY: in_fire -> ONE, main<=in.
  - ONE, in_fire & out_fire -> ONE, main<=in.
  - ONE, in_fire only -> FULL, skid<=in.
  - ONE, out_fire only -> EMPTY.
  - FULL: out_fire -> ONE, main<=skid. dec_valid_i is ignored because dec_ready_o=0.
  - dec_ready_o = (state != FULL) and is purely registered, with no combinational path from exe_ready_i.
  - exe_valid_o = (state != EMPTY).
- SKID_EN=0:
  - States are EMPTY and ONE only.
  - dec_ready_o = !exe_valid_o | exe_ready_i (combinational).
  - Simultaneous in/out fire replaces main.
- Stall (exe_valid_o=1, exe_ready_i=0): payload outputs hold stable and exe_valid_o stays 1 until out_fire.
- Counters:
  - Each increments by 1 on its qualifying cycle and saturates at 2^CNT_W-1.
  - Cleared only by reset.

Decomposition:
- Shared package (pipeline package): state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2, plus default payload widths.
- One natural sub-module: sat_counter (parameter W; inc_i, count_o, sync active-low reset), instantiated twice.
- The payload register set is written inline in this block.

Test Plan:
- Reset: hold rsn_i=0 for 2 cycles with dec_valid_i=1 -> exe_valid_o=0, all payload outputs 0, counters 0; dec_ready_o=1 after release.
- Streaming: exe_ready_i=1; present pc 0x100, 0x104 and 0x108 on consecutive cycles -> exe_pc_o shows 0x100, 0x104, 0x108 one cycle later each; stall_cnt_o=0.
- Backpressure (SKID_EN=1): exe_ready_i=0; send pc 0x200 then 0x204 -> dec_ready_o falls after the second accept. Raising exe_ready_i yields 0x200 then 0x204 in order; stall_cnt_o counts the held cycles exactly.
- Kill while FULL with simultaneous dec_valid_i (pc 0x300) -> next cycle exe_valid_o=0, exe_int_write_enable_o=0, payload 0; 0x300 is never delivered; dec_ready_o=1.
- SKID_EN=0: exe_ready_i=0 with an entry held -> dec_ready_o=0 in the same cycle. Raising exe_ready_i with dec_valid_i=1 -> dec_ready_o=1 combinationally and the new entry replaces the old.
- Counter saturation (CNT_W=4): 20 idle cycles with exe_ready_i=1 -> bubble_cnt_o stops at 15.

Source files
------------

// File: rtl/dec_exe_skid_stage_pkg.sv
// Shared definitions for the decode-to-execute pipeline stage.
package dec_exe_skid_stage_pkg;

    // Default payload / counter widths
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_INSTR_W = 32;
    localparam int DEF_PC_W    = 32;
    localparam int DEF_CNT_W   = 16;

    // Occupancy state: EMPTY, main entry held, main + skid entry held
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/dec_exe_skid_stage_sat_counter.sv
// Saturating up-counter with synchronous active-low reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rsn_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Increment on request unless already at all-ones
    always_comb begin
        count_d = count_q;
        if (inc_i && !(&count_q)) begin
            count_d = count_q + W'(1);
        end
    end

    // Counter register, cleared only by reset
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/dec_exe_skid_stage.sv
// Decode-to-execute stage: valid/ready on both sides, optional two-entry
// skid buffer, kill flush and saturating stall/bubble counters.
module dec_exe_skid_stage
    import dec_exe_skid_stage_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter int PC_W    = DEF_PC_W,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk_i,
    input  logic               rsn_i,
    input  logic               kill_i,
    input  logic               dec_valid_i,
    output logic               dec_ready_o,
    input  logic [DATA_W-1:0]  dec_read_data_a_i,
    input  logic [DATA_W-1:0]  dec_read_data_b_i,
    input  logic [ADDR_W-1:0]  dec_write_addr_i,
    input  logic               dec_int_write_enable_i,
    input  logic [INSTR_W-1:0] dec_instruction_i,
    input  logic [PC_W-1:0]    dec_pc_i,
    output logic               exe_valid_o,
    input  logic               exe_ready_i,
    output logic [DATA_W-1:0]  exe_read_data_a_o,
    output logic [DATA_W-1:0]  exe_read_data_b_o,
    output logic [ADDR_W-1:0]  exe_write_addr_o,
    output logic               exe_int_write_enable_o,
    output logic [INSTR_W-1:0] exe_instruction_o,
    output logic [PC_W-1:0]    exe_pc_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic [CNT_W-1:0]   bubble_cnt_o
);

    pipe_state_e state_q;
    pipe_state_e state_d;

    // Main (head) entry
    logic [DATA_W-1:0]  a_q;
    logic [DATA_W-1:0]  b_q;
    logic [ADDR_W-1:0]  wa_q;
    logic               we_q;
    logic [INSTR_W-1:0] ins_q;
    logic [PC_W-1:0]    pc_q;

    // Skid entry, only ever loaded when SKID_EN != 0
    logic [DATA_W-1:0]  sa_q;
    logic [DATA_W-1:0]  sb_q;
    logic [ADDR_W-1:0]  swa_q;
    logic               swe_q;
    logic [INSTR_W-1:0] sins_q;
    logic [PC_W-1:0]    spc_q;

    logic in_fire;
    logic out_fire;
    logic ld_main_in;
    logic ld_main_skid;
    logic ld_skid;

    assign exe_valid_o = (state_q != ST_EMPTY);
    assign in_fire     = dec_valid_i & dec_ready_o;
    assign out_fire    = exe_valid_o & exe_ready_i;

    // Upstream ready: registered (state decode) with skid, combinational without.
    // Held high through reset so decode sees the stage as open immediately.
    generate
        if (SKID_EN != 0) begin : g_ready_skid
            assign dec_ready_o = !rsn_i || (state_q != ST_FULL);
        end else begin : g_ready_comb
            assign dec_ready_o = !rsn_i || !exe_valid_o || exe_ready_i;
        end
    endgenerate

    // Next occupancy state and which payload registers load; kill overrides all
    always_comb begin
        state_d      = state_q;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    state_d    = ST_ONE;
                    ld_main_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    ld_main_in = 1'b1;
                end else if (in_fire) begin
                    if (SKID_EN != 0) begin
                        state_d = ST_FULL;
                        ld_skid = 1'b1;
                    end else begin
                        // Unreachable: without skid, accept while held implies out_fire
                        ld_main_in = 1'b1;
                    end
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    state_d      = ST_ONE;
                    ld_main_skid = 1'b1;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
        if (kill_i) begin
            state_d      = ST_EMPTY;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
        end
    end

    // Occupancy state register
    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers: zeroed by reset or kill, otherwise loaded per FSM
    always_ff @(posedge clk_i) begin
        if (!rsn_i || kill_i) begin
            a_q    <= '0;
            b_q    <= '0;
            wa_q   <= '0;
            we_q   <= 1'b0;
            ins_q  <= '0;
            pc_q   <= '0;
            sa_q   <= '0;
            sb_q   <= '0;
            swa_q  <= '0;
            swe_q  <= 1'b0;
            sins_q <= '0;
            spc_q  <= '0;
        end else begin
            if (ld_main_in) begin
                a_q   <= dec_read_data_a_i;
                b_q   <= dec_read_data_b_i;
                wa_q  <= dec_write_addr_i;
                we_q  <= dec_int_write_enable_i;
                ins_q <= dec_instruction_i;
                pc_q  <= dec_pc_i;
            end else if (ld_main_skid) begin
                a_q   <= sa_q;
                b_q   <= sb_q;
                wa_q  <= swa_q;
                we_q  <= swe_q;
                ins_q <= sins_q;
                pc_q  <= spc_q;
            end
            if (ld_skid) begin
                sa_q   <= dec_read_data_a_i;
                sb_q   <= dec_read_data_b_i;
                swa_q  <= dec_write_addr_i;
                swe_q  <= dec_int_write_enable_i;
                sins_q <= dec_instruction_i;
                spc_q  <= dec_pc_i;
            end
        end
    end

    assign exe_read_data_a_o      = a_q;
    assign exe_read_data_b_o      = b_q;
    assign exe_write_addr_o       = wa_q;
    assign exe_int_write_enable_o = we_q & exe_valid_o;
    assign exe_instruction_o      = ins_q;
    assign exe_pc_o               = pc_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .inc_i   (exe_valid_o & !exe_ready_i),
        .count_o (stall_cnt_o)
    );

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk_i   (clk_i),
        .rsn_i   (rsn_i),
        .inc_i   (!exe_valid_o & exe_ready_i),
        .count_o (bubble_cnt_o)
    );

endmodule
